// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes, types and constants for the register file
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 3;
    localparam int ZERO_ADDRESS = 0;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/register_scoreboard.sv
// rtl/register_scoreboard.sv - busy bits for registers with an outstanding producer
module register_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ZERO_REG   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write0,
    input  logic [ADDR_WIDTH-1:0]        write0Address,
    input  logic                         write1,
    input  logic [ADDR_WIDTH-1:0]        write1Address,
    input  logic                         reserve,
    input  logic [ADDR_WIDTH-1:0]        reserveAddress,
    output logic [(1<<ADDR_WIDTH)-1:0]   busyVector,
    output logic                         reserveConflict
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic             reserve_hit;
    logic [DEPTH-1:0] busy_next;

    assign reserve_hit = reserve &&
        !((ZERO_REG != 0) && (reserveAddress == ADDR_WIDTH'(ZERO_ADDRESS)));

    // Reserve is applied after the write clears so a new producer wins.
    always_comb begin
        busy_next = busyVector;
        if (write0) busy_next[write0Address] = 1'b0;
        if (write1) busy_next[write1Address] = 1'b0;
        if (reserve_hit) busy_next[reserveAddress] = 1'b1;
        if (ZERO_REG != 0) busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busyVector      <= '0;
            reserveConflict <= 1'b0;
        end else begin
            busyVector      <= busy_next;
            reserveConflict <= reserve_hit && busyVector[reserveAddress];
        end
    end

endmodule

// File: rtl/parametric_register_file.sv
// rtl/parametric_register_file.sv - two-write, two-read register file with bypass and scoreboard
module parametric_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        write0,
    input  logic [ADDR_WIDTH-1:0]       write0Address,
    input  logic [DATA_WIDTH-1:0]       write0Data,
    input  logic                        write1,
    input  logic [ADDR_WIDTH-1:0]       write1Address,
    input  logic [DATA_WIDTH-1:0]       write1Data,
    input  logic [ADDR_WIDTH-1:0]       out1Address,
    input  logic [ADDR_WIDTH-1:0]       out2Address,
    output logic [DATA_WIDTH-1:0]       out1,
    output logic [DATA_WIDTH-1:0]       out2,
    output logic                        out1Busy,
    output logic                        out2Busy,
    input  logic                        reserve,
    input  logic [ADDR_WIDTH-1:0]       reserveAddress,
    output logic                        reserveConflict,
    output logic [(1<<ADDR_WIDTH)-1:0]  busyVector
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_ADDRESS);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  commit0;
    logic                  commit1;

    assign commit0 = write0 && !((ZERO_REG != 0) && (write0Address == ZERO));
    assign commit1 = write1 && !((ZERO_REG != 0) && (write1Address == ZERO));

    // Port 1 is assigned last so it overwrites port 0 on an address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (commit0) regs[write0Address] <= write0Data;
            if (commit1) regs[write1Address] <= write1Data;
        end
    end

    always_comb begin
        out1 = regs[out1Address];
        out2 = regs[out2Address];
        if (BYPASS != 0) begin
            if (write0 && (write0Address == out1Address)) out1 = write0Data;
            if (write1 && (write1Address == out1Address)) out1 = write1Data;
            if (write0 && (write0Address == out2Address)) out2 = write0Data;
            if (write1 && (write1Address == out2Address)) out2 = write1Data;
        end
        if ((ZERO_REG != 0) && (out1Address == ZERO)) out1 = '0;
        if ((ZERO_REG != 0) && (out2Address == ZERO)) out2 = '0;
    end

    assign out1Busy = busyVector[out1Address];
    assign out2Busy = busyVector[out2Address];

    register_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) scoreboard (
        .clk             (clk),
        .reset           (reset),
        .write0          (write0),
        .write0Address   (write0Address),
        .write1          (write1),
        .write1Address   (write1Address),
        .reserve         (reserve),
        .reserveAddress  (reserveAddress),
        .busyVector      (busyVector),
        .reserveConflict (reserveConflict)
    );

endmodule

// File: tb/tb_parametric_register_file.sv
// tb/tb_parametric_register_file.sv - checks three configurations against a behavioural model
module tb_parametric_register_file;

    logic       clk;
    logic       reset;
    logic       write0, write1, reserve;
    logic [2:0] write0Address, write1Address, reserveAddress;
    logic [7:0] write0Data, write1Data;
    logic [2:0] out1Address, out2Address;

    // index 0: BYPASS=1 ZERO_REG=0, 1: BYPASS=0 ZERO_REG=0, 2: BYPASS=1 ZERO_REG=1
    logic [7:0] o1 [3];
    logic [7:0] o2 [3];
    logic       b1 [3];
    logic       b2 [3];
    logic       rc [3];
    logic [7:0] bv [3];

    logic [7:0] mem  [3][8];
    logic [7:0] busy [3];
    logic       cf   [3];

    int total = 0;
    int bad   = 0;

    parametric_register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset),
        .write0(write0), .write0Address(write0Address), .write0Data(write0Data),
        .write1(write1), .write1Address(write1Address), .write1Data(write1Data),
        .out1Address(out1Address), .out2Address(out2Address),
        .out1(o1[0]), .out2(o2[0]), .out1Busy(b1[0]), .out2Busy(b2[0]),
        .reserve(reserve), .reserveAddress(reserveAddress),
        .reserveConflict(rc[0]), .busyVector(bv[0])
    );

    parametric_register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(0), .ZERO_REG(0)) dut_n (
        .clk(clk), .reset(reset),
        .write0(write0), .write0Address(write0Address), .write0Data(write0Data),
        .write1(write1), .write1Address(write1Address), .write1Data(write1Data),
        .out1Address(out1Address), .out2Address(out2Address),
        .out1(o1[1]), .out2(o2[1]), .out1Busy(b1[1]), .out2Busy(b2[1]),
        .reserve(reserve), .reserveAddress(reserveAddress),
        .reserveConflict(rc[1]), .busyVector(bv[1])
    );

    parametric_register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset),
        .write0(write0), .write0Address(write0Address), .write0Data(write0Data),
        .write1(write1), .write1Address(write1Address), .write1Data(write1Data),
        .out1Address(out1Address), .out2Address(out2Address),
        .out1(o1[2]), .out2(o2[2]), .out1Busy(b1[2]), .out2Busy(b2[2]),
        .reserve(reserve), .reserveAddress(reserveAddress),
        .reserveConflict(rc[2]), .busyVector(bv[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit byp(input int c);
        return c != 1;
    endfunction

    function automatic bit zr(input int c);
        return c == 2;
    endfunction

    function automatic logic [7:0] exp_read(input int c, input logic [2:0] a);
        logic [7:0] v;
        if (zr(c) && a == 3'd0) return 8'd0;
        v = mem[c][a];
        if (byp(c)) begin
            if (write0 && write0Address == a) v = write0Data;
            if (write1 && write1Address == a) v = write1Data;
        end
        return v;
    endfunction

    task automatic idle();
        reset = 1'b1; write0 = 1'b0; write1 = 1'b0; reserve = 1'b0;
        write0Address = 3'd0; write1Address = 3'd0; reserveAddress = 3'd0;
        write0Data = 8'd0; write1Data = 8'd0;
    endtask

    // Advance one clock and apply the architectural effect of the inputs to the model.
    task automatic tick();
        bit hit;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            if (!reset) begin
                for (int r = 0; r < 8; r++) mem[c][r] = 8'd0;
                busy[c] = 8'd0;
                cf[c]   = 1'b0;
            end else begin
                hit = reserve && !(zr(c) && reserveAddress == 3'd0);
                cf[c] = hit && busy[c][reserveAddress];
                if (write0 && !(zr(c) && write0Address == 3'd0)) mem[c][write0Address] = write0Data;
                if (write1 && !(zr(c) && write1Address == 3'd0)) mem[c][write1Address] = write1Data;
                if (write0) busy[c][write0Address] = 1'b0;
                if (write1) busy[c][write1Address] = 1'b0;
                if (hit) busy[c][reserveAddress] = 1'b1;
                if (zr(c)) busy[c][0] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0; write0 = 1'b1; write0Address = 3'd2; write0Data = 8'd55;
        tick();
        idle();
        out1Address = 3'd0; out2Address = 3'd2;
        #1;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (o1[c] !== 8'd0) begin bad++; $display("FAIL reset_out1 dut%0d got=%0h want=0", c, o1[c]); end
            total++;
            if (o2[c] !== 8'd0) begin bad++; $display("FAIL reset_out2 dut%0d got=%0h want=0", c, o2[c]); end
            total++;
            if (bv[c] !== 8'd0 || rc[c] !== 1'b0) begin
                bad++; $display("FAIL reset_busy dut%0d got bv=%0h rc=%0b want 0", c, bv[c], rc[c]);
            end
        end
    endtask

    task automatic test_bypass();
        idle();
        write0 = 1'b1; write0Address = 3'd0; write0Data = 8'd24; out1Address = 3'd0;
        #1;
        total++;
        if (o1[0] !== 8'd24) begin bad++; $display("FAIL bypass_on got=%0d want=24", o1[0]); end
        total++;
        if (o1[1] !== 8'd0) begin bad++; $display("FAIL bypass_off_pre got=%0d want=0", o1[1]); end
        total++;
        if (o1[2] !== 8'd0) begin bad++; $display("FAIL bypass_zero got=%0d want=0", o1[2]); end
        tick();
        idle();
        #1;
        total++;
        if (o1[1] !== 8'd24) begin bad++; $display("FAIL bypass_off_post got=%0d want=24", o1[1]); end
    endtask

    task automatic test_collision();
        idle();
        write0 = 1'b1; write0Address = 3'd4; write0Data = 8'd12;
        write1 = 1'b1; write1Address = 3'd4; write1Data = 8'd99;
        out2Address = 3'd4;
        #1;
        total++;
        if (o2[0] !== 8'd99) begin bad++; $display("FAIL collision_bypass got=%0d want=99", o2[0]); end
        tick();
        idle();
        out1Address = 3'd4;
        #1;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (o1[c] !== 8'd99) begin bad++; $display("FAIL collision_r4 dut%0d got=%0d want=99", c, o1[c]); end
        end
        write0 = 1'b1; write0Address = 3'd5; write0Data = 8'd7;
        write1 = 1'b1; write1Address = 3'd6; write1Data = 8'd8;
        tick();
        idle();
        out1Address = 3'd5; out2Address = 3'd6;
        #1;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (o1[c] !== 8'd7 || o2[c] !== 8'd8) begin
                bad++; $display("FAIL dual_write dut%0d got=%0d,%0d want=7,8", c, o1[c], o2[c]);
            end
        end
    endtask

    task automatic test_zero_reg();
        idle();
        write0 = 1'b1; write0Address = 3'd0; write0Data = 8'd200;
        reserve = 1'b1; reserveAddress = 3'd0; out1Address = 3'd0;
        #1;
        total++;
        if (o1[2] !== 8'd0) begin bad++; $display("FAIL zero_bypass got=%0d want=0", o1[2]); end
        tick();
        write0 = 1'b0;
        tick();
        idle();
        out1Address = 3'd0;
        #1;
        total++;
        if (o1[2] !== 8'd0) begin bad++; $display("FAIL zero_read got=%0d want=0", o1[2]); end
        total++;
        if (bv[2][0] !== 1'b0 || rc[2] !== 1'b0) begin
            bad++; $display("FAIL zero_busy got bv0=%0b rc=%0b want 0,0", bv[2][0], rc[2]);
        end
        total++;
        if (o1[0] !== 8'd200 || rc[0] !== 1'b1) begin
            bad++; $display("FAIL nonzero_r0 got=%0d rc=%0b want=200 rc=1", o1[0], rc[0]);
        end
        write0 = 1'b1; write0Address = 3'd0; write0Data = 8'd1;
        tick();
        idle();
    endtask

    task automatic test_scoreboard();
        idle();
        reserve = 1'b1; reserveAddress = 3'd3;
        tick();
        reserve = 1'b0; out2Address = 3'd3;
        #1;
        total++;
        if (b2[0] !== 1'b1) begin bad++; $display("FAIL reserve_busy got=%0b want=1", b2[0]); end
        total++;
        if (rc[0] !== 1'b0) begin bad++; $display("FAIL first_reserve_conflict got=%0b want=0", rc[0]); end
        reserve = 1'b1;
        tick();
        reserve = 1'b0;
        #1;
        total++;
        if (rc[0] !== 1'b1 || bv[0][3] !== 1'b1) begin
            bad++; $display("FAIL conflict_pulse got rc=%0b busy=%0b want 1,1", rc[0], bv[0][3]);
        end
        tick();
        total++;
        if (rc[0] !== 1'b0) begin bad++; $display("FAIL conflict_width got=%0b want=0", rc[0]); end
        write1 = 1'b1; write1Address = 3'd3; write1Data = 8'd42;
        #1;
        total++;
        if (b2[0] !== 1'b1) begin bad++; $display("FAIL busy_not_bypassed got=%0b want=1", b2[0]); end
        tick();
        idle();
        out2Address = 3'd3;
        #1;
        total++;
        if (bv[0][3] !== 1'b0 || o2[0] !== 8'd42) begin
            bad++; $display("FAIL write_clears got busy=%0b data=%0d want 0,42", bv[0][3], o2[0]);
        end
        reserve = 1'b1; reserveAddress = 3'd3;
        write0 = 1'b1; write0Address = 3'd3; write0Data = 8'd17;
        tick();
        idle();
        #1;
        total++;
        if (bv[0][3] !== 1'b1 || rc[0] !== 1'b0) begin
            bad++; $display("FAIL reserve_beats_write got busy=%0b rc=%0b want 1,0", bv[0][3], rc[0]);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        write0 = 1'b1; write0Address = 3'd1; write0Data = 8'd5;
        tick();
        idle();
        reserve = 1'b1; reserveAddress = 3'd1;
        tick();
        reserve = 1'b1;
        tick();
        idle();
        out1Address = 3'd1;
        #1;
        total++;
        if (o1[0] !== 8'd5 || bv[0][1] !== 1'b1 || rc[0] !== 1'b1) begin
            bad++; $display("FAIL pre_reset got=%0d busy=%0b rc=%0b want 5,1,1", o1[0], bv[0][1], rc[0]);
        end
        reset = 1'b0; write1 = 1'b1; write1Address = 3'd1; write1Data = 8'd9;
        tick();
        idle();
        out1Address = 3'd1;
        #1;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (o1[c] !== 8'd0 || bv[c] !== 8'd0 || rc[c] !== 1'b0) begin
                bad++; $display("FAIL reset_mid dut%0d got=%0d bv=%0h rc=%0b want 0,0,0", c, o1[c], bv[c], rc[c]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset          = ($urandom_range(0, 39) != 0);
            write0         = $urandom_range(0, 1) == 1;
            write1         = $urandom_range(0, 1) == 1;
            reserve        = $urandom_range(0, 2) == 0;
            write0Address  = 3'($urandom_range(0, 7));
            write1Address  = 3'($urandom_range(0, 7));
            reserveAddress = 3'($urandom_range(0, 7));
            write0Data     = 8'($urandom);
            write1Data     = 8'($urandom);
            out1Address    = 3'($urandom_range(0, 7));
            out2Address    = 3'($urandom_range(0, 7));
            #1;
            for (int c = 0; c < 3; c++) begin
                total++;
                if (o1[c] !== exp_read(c, out1Address)) begin
                    bad++; $display("FAIL rand_out1 dut%0d got=%0h want=%0h", c, o1[c], exp_read(c, out1Address));
                end
                total++;
                if (o2[c] !== exp_read(c, out2Address)) begin
                    bad++; $display("FAIL rand_out2 dut%0d got=%0h want=%0h", c, o2[c], exp_read(c, out2Address));
                end
                total++;
                if (b1[c] !== busy[c][out1Address] || b2[c] !== busy[c][out2Address]) begin
                    bad++; $display("FAIL rand_outbusy dut%0d got=%0b%0b want=%0b%0b", c, b1[c], b2[c],
                                    busy[c][out1Address], busy[c][out2Address]);
                end
                total++;
                if (bv[c] !== busy[c]) begin
                    bad++; $display("FAIL rand_busyvec dut%0d got=%0h want=%0h", c, bv[c], busy[c]);
                end
                total++;
                if (rc[c] !== cf[c]) begin
                    bad++; $display("FAIL rand_conflict dut%0d got=%0b want=%0b", c, rc[c], cf[c]);
                end
            end
            tick();
        end
    endtask

    initial begin
        idle();
        out1Address = 3'd0;
        out2Address = 3'd0;
        test_reset();
        test_bypass();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
